// File: rtl/nn_pkg.sv
// Shared constants, state enum and helpers for the MNIST output stage.
// Used by nn_output_classifier and nn_avl_rd_tracker.
package nn_pkg;
  localparam int N_HID           = 200;
  localparam int N_CLASS         = 10;
  localparam int WORDS_PER_CLASS = 201;
  localparam int ACC_W           = 24;
  localparam int MAX_PENDING     = 8;
  localparam int CNT_W           = 12;

  localparam logic [31:0] HID_BASE    = 32'd300000;
  localparam logic [31:0] W_BASE      = 32'd200000;
  localparam logic [31:0] RESULT_BASE = 32'd310000;
  localparam logic [31:0] SCORE_BASE  = 32'd320000;

  localparam logic [CNT_W-1:0] N_HID_RD = 12'd200;
  localparam logic [CNT_W-1:0] N_OUT_RD = 12'd2010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_HID,
    S_LOAD_OUT,
    S_WRITE,
    S_DUMP,
    S_DONE
  } state_t;

  function automatic logic [15:0] sat16(
    input logic signed [ACC_W-1:0] a
  );
    if (a > 24'sd32767)       return 16'h7fff;
    else if (a < -24'sd32768) return 16'h8000;
    else                      return a[15:0];
  endfunction
endpackage

// File: rtl/nn_avl_rd_tracker.sv
// Avalon read tracker: issued/received counters and outstanding-read gating.
// Ports: i_clr zeroes both counters; o_can_issue allows a new request.
module nn_avl_rd_tracker
  import nn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_accept,
  input  logic             i_rvalid,
  input  logic [CNT_W-1:0] i_total,
  output logic [CNT_W-1:0] o_issued,
  output logic             o_can_issue,
  output logic             o_all_recv
);
  localparam logic [CNT_W-1:0] MAXP = CNT_W'(MAX_PENDING);

  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_received;
  logic [CNT_W-1:0] w_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued   <= '0;
      r_received <= '0;
    end else if (i_clr) begin
      r_issued   <= '0;
      r_received <= '0;
    end else begin
      if (i_accept) r_issued   <= r_issued + 1'b1;
      if (i_rvalid) r_received <= r_received + 1'b1;
    end
  end

  assign w_pend      = r_issued - r_received;
  assign o_issued    = r_issued;
  assign o_can_issue = (r_issued < i_total) && (w_pend < MAXP);
  assign o_all_recv  = (r_received == i_total);
endmodule

// File: rtl/nn_output_classifier.sv
// MNIST output layer: binarize hidden sums, score 10 classes, write argmax.
// Ports: start/img_idx in, busy/done/class_out out, Avalon-MM master.
// Macro CLASSIFIER_SCORE_DUMP_EN adds a saturated per-class score dump.
module nn_output_classifier
  import nn_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [15:0]        img_idx,
  output logic               busy,
  output logic               done,
  output logic [3:0]         class_out,
  output logic [31:0]        address,
  output logic               chipselect,
  output logic               read_n,
  output logic               write_n,
  output logic [1:0]         byteenable,
  output logic signed [15:0] writedata,
  input  logic signed [15:0] readdata,
  input  logic               readdatavalid,
  input  logic               waitrequest
);
  state_t r_state, w_next;

  logic [15:0]             r_img;
  logic [N_HID-1:0]        r_hbit;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_best;
  logic [3:0]              r_best_idx;
  logic [3:0]              r_cls;
  logic [7:0]              r_r;
  logic [3:0]              r_class;
`ifdef CLASSIFIER_SCORE_DUMP_EN
  logic signed [ACC_W-1:0] r_score [N_CLASS];
  logic [3:0]              r_dcnt;
`endif

  logic                    w_in_load;
  logic [CNT_W-1:0]        w_total;
  logic [CNT_W-1:0]        w_issued;
  logic                    w_can_issue;
  logic                    w_all_recv;
  logic                    w_accept;
  logic                    w_rvalid;
  logic                    w_clr;
  logic                    w_wr_ack;
  logic                    w_hsel;
  logic                    w_last;
  logic signed [ACC_W-1:0] w_sext;
  logic signed [ACC_W-1:0] w_acc_nxt;

  assign w_in_load = (r_state == S_LOAD_HID) || (r_state == S_LOAD_OUT);
  assign w_total   = (r_state == S_LOAD_HID) ? N_HID_RD : N_OUT_RD;
  assign w_accept  = !read_n && !waitrequest;
  assign w_wr_ack  = !write_n && !waitrequest;
  // Responses outside a load phase are stale and must not count.
  assign w_rvalid  = readdatavalid && w_in_load;
  assign w_clr     = (r_state != w_next);

  nn_avl_rd_tracker u_trk (
    .clk         (clk),
    .rst_n       (reset_n),
    .i_clr       (w_clr),
    .i_accept    (w_accept),
    .i_rvalid    (w_rvalid),
    .i_total     (w_total),
    .o_issued    (w_issued),
    .o_can_issue (w_can_issue),
    .o_all_recv  (w_all_recv)
  );

  // r_r is the response index within a class (word 0 = bias).
  assign w_sext    = {{(ACC_W-16){readdata[15]}}, readdata};
  assign w_hsel    = (r_r != 8'd0) && r_hbit[r_r - 8'd1];
  assign w_last    = (r_r == 8'(N_HID));
  assign w_acc_nxt = (r_r == 8'd0) ? w_sext :
                     (w_hsel ? r_acc + w_sext : r_acc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (start) w_next = S_LOAD_HID;
      S_LOAD_HID: if (w_all_recv) w_next = S_LOAD_OUT;
      S_LOAD_OUT: if (w_all_recv) w_next = S_WRITE;
`ifdef CLASSIFIER_SCORE_DUMP_EN
      S_WRITE:    if (w_wr_ack) w_next = S_DUMP;
      S_DUMP:     if (w_wr_ack && r_dcnt == 4'd9) w_next = S_DONE;
`else
      S_WRITE:    if (w_wr_ack) w_next = S_DONE;
      S_DUMP:     w_next = S_IDLE;
`endif
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_img      <= '0;
      r_hbit     <= '0;
      r_acc      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_cls      <= '0;
      r_r        <= '0;
      r_class    <= '0;
`ifdef CLASSIFIER_SCORE_DUMP_EN
      r_dcnt     <= '0;
      for (int i = 0; i < N_CLASS; i++) r_score[i] <= '0;
`endif
    end else begin
      if (r_state == S_IDLE && start) begin
        r_img <= img_idx;
        r_cls <= '0;
        r_acc <= '0;
`ifdef CLASSIFIER_SCORE_DUMP_EN
        r_dcnt <= '0;
`endif
      end
      if (w_clr) r_r <= '0;
      if (w_rvalid && r_state == S_LOAD_HID) begin
        r_hbit[r_r] <= ~readdata[15];
        r_r         <= r_r + 8'd1;
      end
      if (w_rvalid && r_state == S_LOAD_OUT) begin
        r_acc <= w_acc_nxt;
        if (w_last) begin
          r_r   <= '0;
          r_cls <= r_cls + 4'd1;
          // Class 0 seeds best; strict > keeps the lowest index on ties.
          if (r_cls == 4'd0 || w_acc_nxt > r_best) begin
            r_best     <= w_acc_nxt;
            r_best_idx <= r_cls;
          end
`ifdef CLASSIFIER_SCORE_DUMP_EN
          r_score[r_cls] <= w_acc_nxt;
`endif
        end else begin
          r_r <= r_r + 8'd1;
        end
      end
`ifdef CLASSIFIER_SCORE_DUMP_EN
      if (r_state == S_DUMP && w_wr_ack) r_dcnt <= r_dcnt + 4'd1;
`endif
      if (w_next == S_DONE && r_state != S_DONE) r_class <= r_best_idx;
    end
  end

  // Bus outputs decode from registered state, so they stay put
  // across waitrequest and drop to idle values on reset.
  always_comb begin
    read_n    = 1'b1;
    write_n   = 1'b1;
    address   = '0;
    writedata = '0;
    if (w_in_load && w_can_issue) begin
      read_n  = 1'b0;
      address = ((r_state == S_LOAD_HID) ? HID_BASE : W_BASE)
              + 32'(w_issued);
    end
    if (r_state == S_WRITE) begin
      write_n   = 1'b0;
      address   = RESULT_BASE + 32'(r_img);
      writedata = {12'd0, r_best_idx};
    end
`ifdef CLASSIFIER_SCORE_DUMP_EN
    if (r_state == S_DUMP) begin
      write_n   = 1'b0;
      address   = SCORE_BASE + 32'(r_img) * 32'd10 + 32'(r_dcnt);
      writedata = sat16(r_score[r_dcnt]);
    end
`endif
  end

  assign chipselect = 1'b1;
  assign byteenable = 2'b11;
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done       = (r_state == S_DONE);
  assign class_out  = r_class;
endmodule

// File: tb/tb_nn_output_classifier.sv
// Directed bench for nn_output_classifier with an Avalon SDRAM slave model.
// Optional dump checks follow CLASSIFIER_SCORE_DUMP_EN.
module tb_nn_output_classifier;
  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [15:0]        img_idx;
  logic               busy;
  logic               done;
  logic [3:0]         class_out;
  logic [31:0]        address;
  logic               chipselect;
  logic               read_n;
  logic               write_n;
  logic [1:0]         byteenable;
  logic signed [15:0] writedata;
  logic signed [15:0] readdata;
  logic               readdatavalid;
  logic               waitrequest;

  nn_output_classifier dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .img_idx       (img_idx),
    .busy          (busy),
    .done          (done),
    .class_out     (class_out),
    .address       (address),
    .chipselect    (chipselect),
    .read_n        (read_n),
    .write_n       (write_n),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .waitrequest   (waitrequest)
  );

  always #5 clk = ~clk;

  logic signed [15:0] hid [200];
  logic signed [15:0] wts [2010];
  logic [15:0]        wmem [int];

  typedef struct {
    int          due;
    logic [15:0] d;
  } rsp_t;
  rsp_t q[$];

  int cyc     = 0;
  int lat     = 6;
  bit wr_rand = 1'b0;
  int max_out = 0;
  int npass   = 0;
  int ntot    = 0;

  function automatic logic [15:0] rd(input logic [31:0] a);
    if (a >= 32'd300000 && a < 32'd300200) return hid[a - 32'd300000];
    if (a >= 32'd200000 && a < 32'd202010) return wts[a - 32'd200000];
    return 16'hdead;
  endfunction

  // Slave: everything decided at negedge takes effect on the next posedge.
  always @(negedge clk) begin
    rsp_t r;
    cyc++;
    waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    if (q.size() > 0 && q[0].due <= cyc) begin
      readdatavalid = 1'b1;
      readdata      = q[0].d;
      void'(q.pop_front());
    end else begin
      readdatavalid = 1'b0;
      readdata      = '0;
    end
    if (reset_n && !read_n && !waitrequest) begin
      r.due = cyc + lat;
      r.d   = rd(address);
      q.push_back(r);
    end
    if (reset_n && !write_n && !waitrequest)
      wmem[int'(address)] = writedata;
    if (reset_n && q.size() > max_out) max_out = q.size();
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] memrd(input int a);
    if (wmem.exists(a)) return {16'd0, wmem[a]};
    return 32'hffffffff;
  endfunction

  function automatic int model_score(input int c);
    int acc;
    acc = int'(wts[201*c]);
    for (int k = 0; k < 200; k++)
      if (hid[k] >= 0) acc += int'(wts[201*c + 1 + k]);
    return acc;
  endfunction

  function automatic int model_class();
    int best, bi, s;
    best = model_score(0);
    bi   = 0;
    for (int c = 1; c < 10; c++) begin
      s = model_score(c);
      if (s > best) begin
        best = s;
        bi   = c;
      end
    end
    return bi;
  endfunction

  task automatic run(input int idx, input int poke, input bit thr,
                     output int cls);
    int cnt;
    @(negedge clk);
    img_idx = 16'(idx);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    cnt = 0;
    while (!done && cnt < 20000) begin
      @(negedge clk);
      cnt++;
      if (cnt == poke) begin
        img_idx = 16'(idx + 100);
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("done_reached", 32'(done), 1);
    if (thr) check("latency_ok", 32'(cnt <= 2240), 1);
    cls = int'(class_out);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
  endtask

  task automatic clear_params();
    for (int i = 0; i < 2010; i++) wts[i] = '0;
  endtask

  initial begin
    int cls, exp;
    reset_n = 1'b0;
    start   = 1'b0;
    img_idx = '0;
    repeat (3) @(negedge clk);
    check("rst_read_n", 32'(read_n), 1);
    check("rst_write_n", 32'(write_n), 1);
    check("rst_cs", 32'(chipselect), 1);
    check("rst_be", 32'(byteenable), 3);
    check("rst_addr", address, 0);
    check("rst_wdata", 32'(writedata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_class", 32'(class_out), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // A: all sums +5, bias c, no weights; late start must be ignored.
    clear_params();
    for (int k = 0; k < 200; k++) hid[k] = 16'sd5;
    for (int c = 0; c < 10; c++) wts[201*c] = 16'(c);
    run(3, 50, 1'b1, cls);
    check("A_class", 32'(cls), 9);
    check("A_mem", memrd(310003), 9);
    check("A_start_ignored", memrd(310103), 32'hffffffff);

    // B: all sums -1, only biases count.
    clear_params();
    for (int k = 0; k < 200; k++) hid[k] = -16'sd1;
    for (int i = 0; i < 2010; i++) wts[i] = 16'sd30000;
    for (int c = 0; c < 10; c++) wts[201*c] = 16'sd0;
    wts[201*2] = 16'sd7;
    run(4, -1, 1'b1, cls);
    check("B_class", 32'(cls), 2);
    check("B_mem", memrd(310004), 2);

    // C: only hidden 17 positive, class 4 weight 1000 there.
    clear_params();
    for (int k = 0; k < 200; k++) hid[k] = -16'sd1;
    hid[17] = 16'sd1;
    for (int c = 0; c < 10; c++) wts[201*c + 1 + 5] = 16'sd5000;
    wts[201*4 + 1 + 17] = 16'sd1000;
    run(5, -1, 1'b1, cls);
    check("C_class", 32'(cls), 4);
    check("C_mem", memrd(310005), 4);
`ifdef CLASSIFIER_SCORE_DUMP_EN
    check("C_score4", memrd(320054), 1000);
    check("C_score0", memrd(320050), 0);
`endif

    // F: a zero sum binarizes to 1.
    clear_params();
    for (int k = 0; k < 200; k++) hid[k] = -16'sd1;
    hid[17] = 16'sd0;
    wts[201*7 + 1 + 17] = -16'sd3;
    wts[201*5 + 1 + 17] = 16'sd2;
    run(6, -1, 1'b1, cls);
    check("F_class", 32'(cls), 5);

    // Tie between 3 and 6, long latency to exercise the pending limit.
    clear_params();
    for (int k = 0; k < 200; k++) hid[k] = 16'sd5;
    for (int c = 0; c < 10; c++) wts[201*c + 1] = 16'sd10;
    wts[201*3 + 1] = 16'sd50;
    wts[201*6 + 1] = 16'sd50;
    lat     = 12;
    max_out = 0;
    run(7, -1, 1'b0, cls);
    check("tie_class", 32'(cls), 3);
    check("pending_cap", 32'(max_out), 8);
    lat = 6;

    // E: large scores, saturated in the dump.
    clear_params();
    for (int k = 0; k < 200; k++) begin
      hid[k]            = 16'sd5;
      wts[1 + k]        = 16'sd30000;
      wts[201 + 1 + k]  = -16'sd30000;
    end
    run(8, -1, 1'b1, cls);
    check("E_class", 32'(cls), 0);
`ifdef CLASSIFIER_SCORE_DUMP_EN
    check("E_sat_pos", memrd(320080), 32'h7fff);
    check("E_sat_neg", memrd(320081), 32'h8000);
    check("E_score2", memrd(320082), 0);
`endif

    // Reset in LOAD_OUT, then a clean rerun with the A pattern.
    clear_params();
    for (int k = 0; k < 200; k++) hid[k] = 16'sd5;
    for (int c = 0; c < 10; c++) wts[201*c] = 16'(c);
    @(negedge clk);
    img_idx = 16'd40;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    check("pending_at_reset", 32'(q.size() > 0), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_read_n", 32'(read_n), 1);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_addr", address, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_rst", 32'(busy), 0);
    run(41, -1, 1'b1, cls);
    check("R_class", 32'(cls), 9);
    check("R_mem", memrd(310041), 9);
    check("R_no_stale_write", memrd(310040), 32'hffffffff);

    // Random images with 50% waitrequest.
    wr_rand = 1'b1;
    max_out = 0;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 200; k++) hid[k] = 16'($urandom);
      for (int i = 0; i < 2010; i++) wts[i] = 16'($urandom);
      exp = model_class();
      run(50 + n, -1, 1'b0, cls);
      check("rand_class", 32'(cls), 32'(exp));
      check("rand_mem", memrd(310050 + n), 32'(exp));
    end
    check("rand_pending_le8", 32'(max_out <= 8), 1);
    wr_rand = 1'b0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
